// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the FSM state encoding, datapath widths and the PC step.
package fetch_controller_pkg;

  localparam int INSTR_W = 18;
  localparam int ADDR_W  = 18;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  localparam logic [ADDR_W-1:0] PC_INC = 18'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_fetch_fifo.sv
// Two-entry fetch buffer holding {pc, instr} pairs between fetch and decode.
// Flush empties it in one cycle; a push into a full buffer only lands alongside a pop.
module fetch_fifo
  import fetch_controller_pkg::*;
#(
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks the PC through external instruction memory,
// buffers fetched words for decode, and handles redirects and end-of-memory drain.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int                MEM_WORDS = 101,
  parameter logic [ADDR_W-1:0] RESET_PC  = 18'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [ADDR_W-1:0]   pc_addr,
  input  logic [INSTR_W-1:0]  instr_rd,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic                if_valid,
  input  logic                id_ready,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                halt
);

  localparam logic [16:0] WORD_LIMIT = 17'(MEM_WORDS);
  localparam logic [15:0] LAST_WORD  = 16'(MEM_WORDS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic                halt_q;
  logic [ADDR_W-1:0]   target;
  logic                target_ok;
  logic                push;
  logic                pop;
  logic                flush;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head;

  assign target    = align_pc(redirect_pc);
  assign target_ok = ({1'b0, target[ADDR_W-1:2]} < WORD_LIMIT);

  // Redirect wins over everything except reset; decode still owns a head it accepted.
  assign pop   = if_valid && id_ready;
  assign flush = redirect && (state != IDLE);
  assign push  = (state == RUN) && en && !redirect && (!fifo_full || pop);

  fetch_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  ({pc, instr_rd}),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign pc_addr  = pc;
  assign if_pc    = head[ENTRY_W-1:INSTR_W];
  assign if_instr = head[INSTR_W-1:0];
  assign if_valid = !fifo_empty;
  assign halt     = halt_q;

  // The end-of-memory test uses the word index of the PC being pushed, so the
  // PC stops one word past the last valid entry and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= align_pc(RESET_PC);
      halt_q <= 1'b0;
    end else if (flush) begin
      pc     <= target;
      state  <= target_ok ? RUN : DRAIN;
      halt_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (push) begin
            pc <= pc + PC_INC;
            if (pc[ADDR_W-1:2] == LAST_WORD) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state  <= DONE;
            halt_q <= 1'b1;
          end
        end
        DONE: begin
          halt_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller; memory word n holds value n and a
// scoreboard queue holds the {pc, instr} pairs decode is expected to receive.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        id_ready;
  logic        redirect;
  logic [17:0] redirect_pc;
  logic [17:0] pc_addr;
  logic [17:0] instr_rd;
  logic [17:0] if_instr;
  logic [17:0] if_pc;
  logic        if_valid;
  logic        halt;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_exp;
  bit          sb_on = 1'b0;

  always #5 clk = ~clk;

  assign instr_rd = {2'b00, pc_addr[17:2]};

  fetch_controller #(
    .MEM_WORDS(101),
    .RESET_PC (18'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pc_addr    (pc_addr),
    .instr_rd   (instr_rd),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .id_ready   (id_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt)
  );

  // Every decode handshake is matched in order against the expected queue.
  always @(negedge clk) begin
    if (sb_on && !rst && if_valid && id_ready) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL sb_transfer: got pc=%0d instr=%0d, required no transfer", if_pc, if_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({if_pc, if_instr} !== mon_exp)
          $display("[TB] FAIL sb_transfer: got pc=%0d instr=%0d, required pc=%0d instr=%0d",
                   if_pc, if_instr, mon_exp[35:18], mon_exp[17:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_words(input int first, input int last);
    for (int n = first; n <= last; n++) exp_q.push_back({18'(n * 4), 18'(n)});
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 18'd100;
    tick(); tick();
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", if_valid); else pass_cnt++;
    check_cnt++; if (halt !== 1'b0) $display("[TB] FAIL reset_halt: got %0b want 0", halt); else pass_cnt++;
    check_cnt++; if (pc_addr !== 18'd0) $display("[TB] FAIL reset_pc: got %0d want 0", pc_addr); else pass_cnt++;
    check_cnt++; if (if_instr !== 18'd0) $display("[TB] FAIL reset_instr: got %0d want 0", if_instr); else pass_cnt++;
    check_cnt++; if (if_pc !== 18'd0) $display("[TB] FAIL reset_ifpc: got %0d want 0", if_pc); else pass_cnt++;
    rst = 1'b0; en = 1'b0; redirect = 1'b0;
    tick(); tick(); tick();
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL idle_valid: got %0b want 0", if_valid); else pass_cnt++;
    check_cnt++; if (pc_addr !== 18'd0) $display("[TB] FAIL idle_pc: got %0d want 0", pc_addr); else pass_cnt++;
  endtask

  task automatic test_stream();
    do_reset();
    en = 1'b1; id_ready = 1'b1;
    expect_words(0, 9);
    tick();
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL stream_first_valid: got %0b want 0", if_valid); else pass_cnt++;
    sb_on = 1'b1;
    tick();
    check_cnt++; if (if_valid !== 1'b1) $display("[TB] FAIL stream_valid: got %0b want 1", if_valid); else pass_cnt++;
    check_cnt++; if (if_pc !== 18'd0) $display("[TB] FAIL stream_ifpc: got %0d want 0", if_pc); else pass_cnt++;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    sb_on = 1'b0;
    check_cnt++; if (exp_q.size() != 0) $display("[TB] FAIL stream_done: got %0d left want 0", exp_q.size()); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_stall();
    int cycles;
    do_reset();
    en = 1'b1; id_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    check_cnt++; if (pc_addr !== 18'd8) $display("[TB] FAIL stall_pc: got %0d want 8", pc_addr); else pass_cnt++;
    check_cnt++; if (if_pc !== 18'd0) $display("[TB] FAIL stall_head: got %0d want 0", if_pc); else pass_cnt++;
    expect_words(0, 4);
    sb_on = 1'b1; id_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 20) begin
      tick();
      cycles++;
    end
    sb_on = 1'b0;
    check_cnt++; if (cycles != 5) $display("[TB] FAIL stall_release: got %0d cycles want 5", cycles); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    en = 1'b1; id_ready = 1'b0;
    tick(); tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 18'd23;
    tick();
    redirect = 1'b0;
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL redir_flush: got %0b want 0", if_valid); else pass_cnt++;
    check_cnt++; if (pc_addr !== 18'd20) $display("[TB] FAIL redir_pc: got %0d want 20", pc_addr); else pass_cnt++;
    tick();
    check_cnt++; if (if_valid !== 1'b1) $display("[TB] FAIL redir_valid: got %0b want 1", if_valid); else pass_cnt++;
    check_cnt++; if (if_pc !== 18'd20) $display("[TB] FAIL redir_ifpc: got %0d want 20", if_pc); else pass_cnt++;
    check_cnt++; if (if_instr !== 18'd5) $display("[TB] FAIL redir_instr: got %0d want 5", if_instr); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_end_of_memory();
    logic [17:0] max_pc;
    do_reset();
    en = 1'b1; id_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 18'd380;
    tick();
    redirect = 1'b0;
    expect_words(95, 100);
    max_pc = pc_addr;
    sb_on = 1'b1;
    for (int i = 0; i < 40 && !halt; i++) begin
      tick();
      if (pc_addr > max_pc) max_pc = pc_addr;
    end
    sb_on = 1'b0;
    check_cnt++; if (halt !== 1'b1) $display("[TB] FAIL end_halt: got %0b want 1", halt); else pass_cnt++;
    check_cnt++; if (exp_q.size() != 0) $display("[TB] FAIL end_drained: got %0d left want 0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (max_pc !== 18'd404) $display("[TB] FAIL end_max_pc: got %0d want 404", max_pc); else pass_cnt++;
    tick(); tick(); tick();
    check_cnt++; if (pc_addr !== 18'd404) $display("[TB] FAIL end_pc_hold: got %0d want 404", pc_addr); else pass_cnt++;
    check_cnt++; if (halt !== 1'b1) $display("[TB] FAIL end_halt_hold: got %0b want 1", halt); else pass_cnt++;
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL end_valid: got %0b want 0", if_valid); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_redirect_out_of_range();
    do_reset();
    en = 1'b1; id_ready = 1'b0;
    tick(); tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 18'd500;
    tick();
    redirect = 1'b0;
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL oob_flush: got %0b want 0", if_valid); else pass_cnt++;
    check_cnt++; if (pc_addr !== 18'd500) $display("[TB] FAIL oob_pc: got %0d want 500", pc_addr); else pass_cnt++;
    for (int i = 0; i < 10 && !halt; i++) tick();
    check_cnt++; if (halt !== 1'b1) $display("[TB] FAIL oob_halt: got %0b want 1", halt); else pass_cnt++;
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL oob_no_push: got %0b want 0", if_valid); else pass_cnt++;
    check_cnt++; if (pc_addr !== 18'd500) $display("[TB] FAIL oob_pc_hold: got %0d want 500", pc_addr); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 18'd8;
    tick();
    redirect = 1'b0;
    check_cnt++; if (halt !== 1'b0) $display("[TB] FAIL resume_halt: got %0b want 0", halt); else pass_cnt++;
    expect_words(2, 4);
    sb_on = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    sb_on = 1'b0;
    check_cnt++; if (exp_q.size() != 0) $display("[TB] FAIL resume_done: got %0d left want 0", exp_q.size()); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    en = 1'b1; id_ready = 1'b0;
    tick(); tick(); tick(); tick();
    check_cnt++; if (if_valid !== 1'b1) $display("[TB] FAIL mid_prefill: got %0b want 1", if_valid); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %0b want 0", if_valid); else pass_cnt++;
    check_cnt++; if (pc_addr !== 18'd0) $display("[TB] FAIL mid_pc: got %0d want 0", pc_addr); else pass_cnt++;
    check_cnt++; if (if_pc !== 18'd0) $display("[TB] FAIL mid_ifpc: got %0d want 0", if_pc); else pass_cnt++;
    tick();
    check_cnt++; if (if_valid !== 1'b0) $display("[TB] FAIL mid_idle: got %0b want 0", if_valid); else pass_cnt++;
    en = 1'b1;
    tick(); tick();
    check_cnt++; if (if_valid !== 1'b1) $display("[TB] FAIL mid_restart_valid: got %0b want 1", if_valid); else pass_cnt++;
    check_cnt++; if (if_pc !== 18'd0) $display("[TB] FAIL mid_restart_pc: got %0d want 0", if_pc); else pass_cnt++;
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_end_of_memory();
    test_redirect_out_of_range();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter MEM_WORDS, default 101, number of valid instruction words; legal word index is 0..MEM_WORDS-1.
REQ-002 Parameter RESET_PC, default 18'd0, byte address fetched first after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  start/continue fetching; sampled each cycle.
REQ-006 pc_addr  output  18  byte address driven to instruction memory; always word aligned, bits [1:0]=00.
REQ-007 instr_rd  input  18  combinational instruction memory read data for pc_addr, same cycle.
REQ-008 if_instr  output  18  instruction at head of fetch buffer.
REQ-009 if_pc  output  18  byte address of if_instr.
REQ-010 if_valid  output  1  head entry valid.
REQ-011 id_ready  input  1  decode accepts head; transfer occurs when if_valid and id_ready both high.
REQ-012 redirect  input  1  branch taken or other control transfer; single-cycle pulse.
REQ-013 redirect_pc  input  18  target byte address; bits [1:0] ignored.
REQ-014 halt  output  1  high in DONE state.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; encoding is free.
REQ-016 IDLE -> RUN when en=1; otherwise remain in IDLE with no memory reads captured.
REQ-017 Fetch buffer: 2-entry FIFO of {pc, instr}; head drives if_pc/if_instr; if_valid = (count != 0).
REQ-018 In RUN with en=1, buffer not full (or full with a pop that cycle), and no redirect: push {pc_addr, instr_rd} and advance pc by 4.
REQ-019 Fetch latency: instruction at pc_addr is visible on if_instr one cycle after capture; throughput one instruction per cycle with id_ready held high.
REQ-020 en=0 in RUN: no push, pc holds, buffer still drains to decode.
REQ-021 Buffer full and no pop: no push, pc holds; no entry is ever overwritten or dropped.
REQ-022 Push and pop in the same cycle: count unchanged, order preserved.
REQ-023 redirect=1 in any state except IDLE: flush buffer (count=0), pc <= {redirect_pc[17:2], 2'b00}, no push that cycle, if_valid=0 next cycle; the state becomes RUN if the target word index < MEM_WORDS, else DRAIN.
REQ-024 redirect overrides push, pop and en in the same cycle; a pop asserted that cycle is still considered consumed by decode.
REQ-025 After a push of word index MEM_WORDS-1, state -> DRAIN; no further pushes.
REQ-026 DRAIN -> DONE when count reaches 0; DONE holds until rst or redirect.
REQ-027 pc arithmetic is 18-bit modulo 2^18; the end-of-memory limit (REQ-025) is checked on the word index pc[17:2] before wrap can occur.
REQ-028 pc_addr equals the internal pc register at all times (registered, glitch-free).

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, pc=RESET_PC, count=0, if_valid=0, halt=0, if_instr=0, if_pc=0.
REQ-030 rst overrides all other inputs including redirect; reset mid-operation discards buffered instructions.

Structure
REQ-031 Shared package holds the FSM state typedef, INSTR_W=18, ADDR_W=18, and the PC increment constant 4.
REQ-032 The fetch buffer is one sub-module, fetch_fifo (depth 2, width 36, with push, pop, flush, full and empty).
REQ-033 The instruction memory stays external; this block only drives pc_addr and samples instr_rd.

Verification
REQ-034 Reset, en=1, id_ready=1, memory word n = n: if_valid rises 1 cycle after entering RUN; if_pc sequence 0,4,8,...; if_instr 0,1,2,....
REQ-035 id_ready=0 for 5 cycles after the first fetch: exactly 2 entries buffered, pc_addr holds at 8; on release, decode receives 0,4,8 in order with no gaps or duplicates.
REQ-036 redirect=1 with redirect_pc=18'd23 while the buffer is full: next cycle if_valid=0 and pc_addr=20; the following cycle if_pc=20.
REQ-037 Fetch runs to word 100 (pc 400): state reaches DRAIN, buffer empties, then halt=1 and pc never exceeds 404.
REQ-038 redirect_pc=18'd500 (word index 125 >= MEM_WORDS): buffer flushed, no push, halt=1 once empty; a later redirect to 8 resumes in RUN.
REQ-039 rst asserted mid-RUN with 2 entries buffered: next cycle IDLE, if_valid=0, pc_addr=RESET_PC.
